display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Scan sequencer for the 4-digit multiplexed 7-segment display.
//  - Walks digit slots 0..3 and drives the active-low anode selects.
//  - Routes the matching BCD/hex nibble of a shadowed 16-bit value to the transcoder.
//  - Inserts an anti-ghosting blank gap, PWM brightness and leading-zero blanking.
//  - Gives the value source tear-free updates: a new value is applied only at frame boundaries.
// PARAMETERS
//  SLOT_CYCLES  20000  clk cycles per digit slot; legal range 16..2^20
//  GAP_CYCLES   400    blank cycles at the start of each slot; (SLOT_CYCLES-GAP_CYCLES) must be >0 and divisible by 8
// PORTS
//  clk           in   1   system clock, single clock domain
//  rst           in   1   synchronous reset, active-high
//  enable        in   1   1 = scan runs; 0 = display dark, scan held at start
//  value         in   16  digit3=[15:12] .. digit0=[3:0]
//  value_load    in   1   1-cycle strobe, captures value into the pending register
//  lz_blank      in   1   1 = blank leading zeros
//  bright        in   3   duty 0..7 -> (bright+1)/8 of the active window
//  an            out  4   anode selects, active-low, one-hot-low or 4'b1111
//  nibble        out  4   code for the current digit, to the transcoder
//  digit_idx     out  2   current slot index
//  frame_done    out  1   1-cycle pulse at the end of the digit-3 slot
//  load_pending  out  1   1 = pending value not yet applied
// BEHAVIOUR
//  Reset
//   - an=4'b1111, nibble=0, digit_idx=0, frame_done=0, load_pending=0.
//   - shadow=0, slot counter cnt=0, state=GAP.
//  Slot counter
//   - cnt runs 0..SLOT_CYCLES-1, then wraps to 0 and digit_idx advances by 1 (3 wraps to 0).
//   - UNIT=(SLOT_CYCLES-GAP_CYCLES)/8; ON_LEN=(bright+1)*UNIT.
//   - bright is sampled at cnt==GAP_CYCLES-1 and held for the whole ON phase.
//  FSM (registered; an/nibble change in the same cycle as the state)
//   - GAP : cnt<GAP_CYCLES. an=1111; nibble=shadow[4*digit_idx+:4]. At cnt==GAP_CYCLES -> ON.
//   - ON  : an[digit_idx]=0 unless blanked. After ON_LEN cycles -> OFF, or -> GAP if bright==7.
//   - OFF : an=1111 until the slot wraps -> GAP.
//  Leading-zero blanking (lz_blank=1)
//   - Digit k (k=3..1) is blanked when all shadow nibbles k..3 are 0.
//   - Digit 0 is never blanked.
//   - A blanked digit keeps an=1111 for its slot; FSM timing is unchanged.
//  Value update
//   - value_load=1: pending<=value, load_pending<=1. A repeated load before the boundary overwrites (last wins).
//   - Frame boundary = wrap of digit 3 into digit 0.
//   - On the boundary: frame_done=1; if load_pending then shadow<=pending and load_pending<=0.
//   - value_load on the boundary cycle: value goes straight into shadow, load_pending stays 0.
//  Nibble codes
//   - Codes >9 pass through unchanged (transcoder shows hex).
//  enable=0
//   - Next cycle: cnt=0, digit_idx=0, state=GAP, an=1111, frame_done=0.
//   - Any pending value is applied on that cycle.
//   - Re-enable starts a fresh frame at digit 0, cnt 0.
//  rst mid-frame
//   - Returns to reset state next cycle and discards pending; an is dark immediately.
// TESTING (SLOT_CYCLES=20, GAP_CYCLES=4, UNIT=2)
//  1 rst, enable=1, bright=7, lz_blank=0, load 16'h1234
//    -> first frame shows 0000; from frame 2, nibble 4,3,2,1 on slots 0..3;
//       an low 16 cycles per slot after a 4-cycle gap; frame_done every 80 cycles.
//  2 bright=0 -> an low exactly 2 cycles per slot (cnt 4..5).
//    bright=3 -> low 8 cycles (cnt 4..11).
//  3 lz_blank=1, shadow=16'h0007 -> only digit 0 lights.
//    shadow=16'h0000 -> digit 0 shows 0; an stays 1111 during the slots of digits 1..3.
//  4 load 16'hAAAA at slot 1, then 16'h5555 at slot 2
//    -> load_pending=1 until the boundary; the next frame shows 5555; AAAA never displayed.
//  5 value_load coincident with the boundary cycle
//    -> shadow updates the same cycle, load_pending stays 0.
//    rst asserted mid-slot -> an=1111 and all outputs at reset values the next cycle.
//  6 enable drops mid-ON -> an=1111 next cycle.
//    Re-enable -> digit_idx=0, 4-cycle gap, then ON.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Scan sequencer for a 4-digit multiplexed 7-segment display.
// Gap/PWM slot timing, leading-zero blanking, frame-aligned value updates.
module display_scan_ctrl #(
  parameter int SLOT_CYCLES = 20000,
  parameter int GAP_CYCLES  = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic        value_load,
  input  logic        lz_blank,
  input  logic [2:0]  bright,
  output logic [3:0]  an,
  output logic [3:0]  nibble,
  output logic [1:0]  digit_idx,
  output logic        frame_done,
  output logic        load_pending
);

  localparam int CW   = $clog2(SLOT_CYCLES + 1);
  localparam int UNIT = (SLOT_CYCLES - GAP_CYCLES) / 8;

  localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GAP  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] GAP1 = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_GAP,
    S_ON,
    S_OFF
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [2:0]    bright_q, bright_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   pend_q, pend_d;
  logic          lp_q, lp_d;
  logic          fd_q, fd_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    nib_q, nib_d;

  logic          last;
  logic          bound;
  logic          blank;
  logic [3:0]    b1;
  logic [CW-1:0] on_len;

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    bright_d = bright_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    lp_d     = lp_q;
    fd_d     = 1'b0;
    last     = (cnt_q == LAST);
    bound    = enable && last && (idx_q == 2'd3);

    if (!enable) begin
      // a disabled display is a safe point to apply the pending value
      cnt_d = '0;
      idx_d = 2'd0;
      lp_d  = 1'b0;
      if (lp_q) shadow_d = pend_q;
      if (value_load) shadow_d = value;
    end else begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
      if (last) idx_d = idx_q + 2'd1;
      if (cnt_q == GAP1) bright_d = bright;
      if (bound) begin
        fd_d = 1'b1;
        lp_d = 1'b0;
        if (lp_q) shadow_d = pend_q;
        if (value_load) shadow_d = value;
      end else if (value_load) begin
        pend_d = value;
        lp_d   = 1'b1;
      end
    end

    b1     = {1'b0, bright_d} + 4'd1;
    on_len = CW'(32'(b1) * 32'(UNIT));

    state_d = state_q;
    if (!enable) begin
      state_d = S_GAP;
    end else begin
      unique case (state_q)
        S_GAP: if (cnt_d == GAP) state_d = S_ON;
        S_ON: begin
          if (cnt_d == '0) state_d = S_GAP;
          else if (cnt_d == GAP + on_len) state_d = S_OFF;
        end
        S_OFF: if (cnt_d == '0) state_d = S_GAP;
        default: state_d = S_GAP;
      endcase
    end

    blank = 1'b0;
    unique case (idx_d)
      2'd1: blank = lz_blank && (shadow_d[15:4] == 12'h000);
      2'd2: blank = lz_blank && (shadow_d[15:8] == 8'h00);
      2'd3: blank = lz_blank && (shadow_d[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase

    an_d = 4'hF;
    if (state_d == S_ON && !blank) an_d[idx_d] = 1'b0;
    nib_d = shadow_d[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_GAP;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      bright_q <= 3'd0;
      shadow_q <= 16'h0000;
      pend_q   <= 16'h0000;
      lp_q     <= 1'b0;
      fd_q     <= 1'b0;
      an_q     <= 4'hF;
      nib_q    <= 4'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      bright_q <= bright_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      lp_q     <= lp_d;
      fd_q     <= fd_d;
      an_q     <= an_d;
      nib_q    <= nib_d;
    end
  end

  assign an           = an_q;
  assign nibble       = nib_q;
  assign digit_idx    = idx_q;
  assign frame_done   = fd_q;
  assign load_pending = lp_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: per-frame scoreboard of nibbles,
// lit-cycle counts and first-lit offsets, plus directed spot checks.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] value;
  logic        value_load;
  logic        lz_blank;
  logic [2:0]  bright;
  logic [3:0]  an;
  logic [3:0]  nibble;
  logic [1:0]  digit_idx;
  logic        frame_done;
  logic        load_pending;

  display_scan_ctrl #(.SLOT_CYCLES(20), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .value(value),
    .value_load(value_load), .lz_blank(lz_blank), .bright(bright),
    .an(an), .nibble(nibble), .digit_idx(digit_idx),
    .frame_done(frame_done), .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] nibs;
    logic [31:0] low;
    logic [31:0] first;
  } frame_t;

  frame_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic push(input logic [15:0] n, input logic [31:0] l,
                      input logic [31:0] f);
    frame_t e;
    e.nibs = n; e.low = l; e.first = f;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    value_load = 1'b1;
    step(1);
    value_load = 1'b0;
  endtask

  // returns at cycle 1 of the next frame
  task automatic wait_frame();
    int t;
    t = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (frame_done !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame_timeout: got no frame_done, expected one within 200 cycles");
    end
    step(1);
  endtask

  // monitor: gathers one frame of display activity, checks on frame_done
  initial begin
    logic [15:0] nibs_m;
    logic [31:0] low_m, first_m;
    logic [3:0]  sel;
    logic [1:0]  prev;
    int len_m, bad_m, pos, k;
    bit fresh;
    frame_t e;
    fresh = 1'b1; nibs_m = '0; low_m = '0; first_m = '1;
    len_m = 0; bad_m = 0; pos = 0; prev = 2'd0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || enable !== 1'b1) begin
        fresh = 1'b1; nibs_m = '0; low_m = '0; first_m = '1;
        len_m = 0; bad_m = 0;
      end else begin
        if (frame_done === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'(len_m), 32'hFFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("frame_nibbles", 32'(nibs_m), 32'(e.nibs));
            chk("frame_lit_cycles", low_m, e.low);
            chk("frame_first_lit", first_m, e.first);
            chk("frame_length", 32'(len_m), 32'd80);
            chk("frame_bad_anode", 32'(bad_m), 32'd0);
          end
          nibs_m = '0; low_m = '0; first_m = '1;
          len_m = 0; bad_m = 0;
        end
        if (fresh || digit_idx != prev) pos = 0;
        else pos++;
        fresh = 1'b0;
        prev = digit_idx;
        k = int'(digit_idx);
        nibs_m[4*k +: 4] = nibble;
        len_m++;
        sel = 4'b0001 << digit_idx;
        if (an == ~sel) begin
          low_m[8*k +: 8] = low_m[8*k +: 8] + 8'd1;
          if (first_m[8*k +: 8] == 8'hFF) first_m[8*k +: 8] = 8'(pos);
        end else if (an != 4'hF) begin
          bad_m++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; value = '0; value_load = 1'b0;
    lz_blank = 1'b0; bright = 3'd0;
    step(3);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_nibble", 32'(nibble), 32'h0);
    chk("rst_digit_idx", 32'(digit_idx), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_load_pending", 32'(load_pending), 32'h0);

    // frame 1 shows reset shadow, 1234 pending
    enable = 1'b1; bright = 3'd7; rst = 1'b0;
    push(16'h0000, 32'h10101010, 32'h04040404);
    pulse_load(16'h1234);
    chk("load_pending_set", 32'(load_pending), 32'h1);
    wait_frame();

    bright = 3'd0;
    push(16'h1234, 32'h02020202, 32'h04040404);
    wait_frame();

    bright = 3'd3;
    push(16'h1234, 32'h08080808, 32'h04040404);
    pulse_load(16'h0007);
    wait_frame();

    bright = 3'd7; lz_blank = 1'b1;
    push(16'h0007, 32'h00000010, 32'hFFFFFF04);
    pulse_load(16'h0000);
    wait_frame();

    // all-zero value: only digit 0 lights; two loads, last wins
    push(16'h0000, 32'h00000010, 32'hFFFFFF04);
    step(24);
    pulse_load(16'hAAAA);
    chk("pending_after_aaaa", 32'(load_pending), 32'h1);
    step(19);
    pulse_load(16'h5555);
    chk("pending_after_5555", 32'(load_pending), 32'h1);
    wait_frame();
    chk("pending_cleared", 32'(load_pending), 32'h0);

    // load coincident with the boundary cycle
    lz_blank = 1'b0;
    push(16'h5555, 32'h10101010, 32'h04040404);
    step(78);
    value = 16'hC0DE; value_load = 1'b1;
    step(1);
    value_load = 1'b0;
    chk("boundary_frame_done", 32'(frame_done), 32'h1);
    chk("boundary_no_pending", 32'(load_pending), 32'h0);
    chk("boundary_nibble", 32'(nibble), 32'hE);
    wait_frame();

    push(16'hC0DE, 32'h10101010, 32'h04040404);
    wait_frame();

    // disable mid-ON with a pending value
    pulse_load(16'h0F00);
    chk("pending_0f00", 32'(load_pending), 32'h1);
    step(8);
    chk("lit_before_disable", 32'(an), 32'hE);
    enable = 1'b0;
    step(1);
    chk("disable_an", 32'(an), 32'hF);
    chk("disable_idx", 32'(digit_idx), 32'h0);
    chk("disable_frame_done", 32'(frame_done), 32'h0);
    chk("disable_applied", 32'(load_pending), 32'h0);
    step(3);
    lz_blank = 1'b1; enable = 1'b1;
    push(16'h0F00, 32'h00101010, 32'hFF040404);
    step(1);
    chk("reenable_idx", 32'(digit_idx), 32'h0);
    chk("reenable_gap", 32'(an), 32'hF);
    wait_frame();

    // reset mid-slot discards pending
    lz_blank = 1'b0;
    pulse_load(16'h9999);
    step(25);
    chk("lit_slot1", 32'(an), 32'hD);
    rst = 1'b1;
    step(1);
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_nibble", 32'(nibble), 32'h0);
    chk("midrst_idx", 32'(digit_idx), 32'h0);
    chk("midrst_frame_done", 32'(frame_done), 32'h0);
    chk("midrst_pending", 32'(load_pending), 32'h0);
    rst = 1'b0;
    push(16'h0000, 32'h10101010, 32'h04040404);
    push(16'h0000, 32'h10101010, 32'h04040404);
    wait_frame();
    wait_frame();
    step(1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
